// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data memory initiator: FSM
//            state encoding, default memory depth, word geometry, and the
//            request address legality check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int unsigned MEM_DEPTH_DEFAULT = 32;
  localparam int unsigned BYTES_PER_WORD    = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_LAST = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } dmem_state_e;

  // A word access is legal only when aligned and its last byte lies inside
  // the memory. The sum is carried in 33 bits so addresses near 2^32 cannot
  // wrap into a small, seemingly legal value.
  function automatic logic addr_is_bad(input logic [31:0] addr,
                                       input int unsigned depth);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'd3;
    return (addr[1:0] != 2'b00) || (last_byte >= {1'b0, depth});
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_initiator_if
// Purpose  : Bundles the request/response handshake and the byte-memory bus
//            of the data memory initiator.
// Ports    : slave  - initiator view (takes requests, drives memory strobes)
//            master - requester/memory view (drives requests and read data)
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_initiator_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        err_o;
  logic        memRead_o;
  logic        memWrite_o;
  logic [31:0] memAddr_o;
  logic [31:0] memWData_o;
  logic [7:0]  memRData_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, memRData_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, err_o,
           memRead_o, memWrite_o, memAddr_o, memWData_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, memRData_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, err_o,
           memRead_o, memWrite_o, memAddr_o, memWData_o
  );

endinterface
`default_nettype wire

// File: rtl/dmem_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : dmem_byte_assembler
// Purpose  : Packs the bytes of a load into a little-endian word. Each
//            captured byte enters at the top and shifts down, so after four
//            captures the first byte sits in [7:0].
// Ports    : clk_i, rst_i (sync, active-low), clear_i (start of a load),
//            capture_i (byte_i valid this cycle), byte_i,
//            word_o (assembled word including any byte captured this cycle)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_byte_assembler
  import dmem_pkg::*;
(
  input  wire logic                          clk_i,
  input  wire logic                          rst_i,
  input  wire logic                          clear_i,
  input  wire logic                          capture_i,
  input  wire logic [7:0]                    byte_i,
  output logic      [8*BYTES_PER_WORD-1:0]   word_o
);

  localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (clear_i) begin
      word_d = '0;
    end else if (capture_i) begin
      word_d = {byte_i, word_q[WORD_W-1:8]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  // Exposing the next value lets the caller latch the word on the same edge
  // that captures the final byte.
  assign word_o = word_d;

endmodule
`default_nettype wire

// File: rtl/data_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_initiator
// Purpose  : Converts 32-bit word load/store requests into four byte accesses
//            on a byte-wide memory with one cycle of read latency.
// Ports    : clk_i  - clock
//            rst_i  - synchronous active-low reset
//            bus    - data_mem_initiator_if.slave (request/response handshake
//                     and byte-memory strobes, address, data)
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_initiator
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int unsigned RD_LAT    = 1
)(
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  data_mem_initiator_if.slave bus
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  dmem_state_e       state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;      // store data, shifted one byte per write
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [RD_LAT-1:0] rd_pend_q, rd_pend_d;  // read strobes in flight
  logic              asm_clear;
  logic [31:0]       asm_word;

  // Read data returns RD_LAT cycles after the strobe; the oldest pending
  // strobe marks the cycle in which memRData_i is valid.
  assign rd_pend_d = (rd_pend_q << 1) | RD_LAT'(mem_read_q);

  dmem_byte_assembler u_asm (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (asm_clear),
    .capture_i (rd_pend_q[RD_LAT-1]),
    .byte_i    (bus.memRData_i),
    .word_o    (asm_word)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    err_d        = err_q;
    rdata_d      = rdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    asm_clear    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i && ready_q) begin
          cnt_d = 2'd0;
          if (addr_is_bad(bus.req_addr_i, MEM_DEPTH)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
          end else if (bus.req_write_i) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_addr_d  = bus.req_addr_i;
            mem_wdata_d = bus.req_wdata_i[7:0];
            wdata_d     = bus.req_wdata_i >> 8;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
            mem_addr_d = bus.req_addr_i;
            asm_clear  = 1'b1;
          end
        end
      end
      RD: begin
        if (cnt_q == LAST_BYTE) begin
          state_d = RD_LAST;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          mem_read_d = 1'b1;
          mem_addr_d = mem_addr_q + 32'd1;
        end
      end
      RD_LAST: begin
        // The final byte arrives this cycle; asm_word already includes it.
        state_d      = RESP;
        resp_valid_d = 1'b1;
        err_d        = 1'b0;
        rdata_d      = asm_word;
      end
      WR: begin
        if (cnt_q == LAST_BYTE) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          err_d        = 1'b0;
          rdata_d      = '0;
        end else begin
          cnt_d       = cnt_q + 2'd1;
          mem_write_d = 1'b1;
          mem_addr_d  = mem_addr_q + 32'd1;
          mem_wdata_d = wdata_q[7:0];
          wdata_d     = wdata_q >> 8;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_pend_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  assign bus.req_ready_o  = ready_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = rdata_q;
  assign bus.err_o        = err_q;
  assign bus.memRead_o    = mem_read_q;
  assign bus.memWrite_o   = mem_write_q;
  assign bus.memAddr_o    = mem_addr_q;
  assign bus.memWData_o   = {24'd0, mem_wdata_q};

endmodule
`default_nettype wire

// File: tb/tb_data_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_initiator
// Purpose  : Self-checking bench for data_mem_initiator: byte memory model,
//            directed vector table, multi-cycle corner sequences and random
//            transactions against a transaction-level reference memory.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_initiator;

  localparam int unsigned DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  data_mem_initiator_if bus ();

  data_mem_initiator #(.MEM_DEPTH(DEPTH), .RD_LAT(1)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [DEPTH];   // memory seen by the DUT
  logic [7:0] ref_mem [DEPTH];   // expected memory contents

  // Byte memory: writes land at the edge, reads return one cycle later.
  // Idle cycles return noise so early or late sampling shows up.
  always @(posedge clk) begin
    if (bus.memWrite_o && bus.memAddr_o < DEPTH)
      mem[bus.memAddr_o[4:0]] <= bus.memWData_o[7:0];
    if (bus.memRead_o && bus.memAddr_o < DEPTH)
      bus.memRData_i <= mem[bus.memAddr_o[4:0]];
    else
      bus.memRData_i <= 8'($urandom);
  end

  // Protocol monitor.
  logic prev_resp = 1'b0;
  always @(negedge clk) begin
    if (bus.memRead_o && bus.memWrite_o) begin
      errors++;
      $display("FAIL strobe_overlap: read=%b write=%b required not both", bus.memRead_o, bus.memWrite_o);
    end
    if ((bus.memRead_o || bus.memWrite_o) && bus.memAddr_o >= DEPTH) begin
      errors++;
      $display("FAIL strobe_range: addr=%h required < %0d", bus.memAddr_o, DEPTH);
    end
    if (prev_resp && bus.resp_valid_o) begin
      errors++;
      $display("FAIL resp_twice: resp_valid_o high two consecutive cycles");
    end
    prev_resp = bus.resp_valid_o;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] a);
    return (a % 4 != 0) || ((longint'(a) + 3) >= longint'(DEPTH));
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_ready"},      bus.req_ready_o,  1'b1);
    chk1({tag, "_resp_valid"}, bus.resp_valid_o, 1'b0);
    chk1({tag, "_err"},        bus.err_o,        1'b0);
    chk ({tag, "_rdata"},      bus.resp_rdata_o, 32'd0);
    chk1({tag, "_memRead"},    bus.memRead_o,    1'b0);
    chk1({tag, "_memWrite"},   bus.memWrite_o,   1'b0);
    chk ({tag, "_memAddr"},    bus.memAddr_o,    32'd0);
    chk ({tag, "_memWData"},   bus.memWData_o,   32'd0);
  endtask

  // Called at a negedge; returns at the first negedge with ready high.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: req_ready_o got 0 required 1 within 20 cycles");
    end
  endtask

  // One request, checked cycle by cycle from the handshake edge T onwards.
  // Between the handshake and the response the request inputs carry noise.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit exp_err, input logic [31:0] exp_rdata);
    bit ok;
    int lat;
    bit exp_rd, exp_wr;
    wait_ready(ok);
    if (!ok) return;
    bus.req_valid_i = 1'b1;
    bus.req_write_i = wr;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    @(negedge clk);
    lat = exp_err ? 1 : (wr ? 5 : 6);
    for (int j = 1; j <= lat + 1; j++) begin
      exp_rd = !exp_err && !wr && (j <= 4);
      exp_wr = !exp_err &&  wr && (j <= 4);
      chk1("ready",      bus.req_ready_o,  j == lat + 1);
      chk1("memRead",    bus.memRead_o,    exp_rd);
      chk1("memWrite",   bus.memWrite_o,   exp_wr);
      chk1("resp_valid", bus.resp_valid_o, j == lat);
      if (exp_rd || exp_wr)
        chk("memAddr", bus.memAddr_o, addr + 32'(j - 1));
      if (exp_wr)
        chk("memWData", bus.memWData_o, {24'd0, wdata[8*(j-1) +: 8]});
      if (j >= lat) begin
        chk1("err", bus.err_o, exp_err);
        if (!wr || exp_err)
          chk("rdata", bus.resp_rdata_o, exp_rdata);
      end
      if (j < lat) begin
        bus.req_valid_i = 1'($urandom);
        bus.req_write_i = 1'($urandom);
        bus.req_addr_i  = $urandom;
        bus.req_wdata_i = $urandom;
      end else begin
        bus.req_valid_i = 1'b0;
      end
      if (j <= lat) @(negedge clk);
    end
    if (wr && !exp_err)
      for (int k = 0; k < 4; k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin : main
    bit ok;
    logic [31:0] w1, w2;
    logic [7:0]  old10, old11;

    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     <= 8'(i * 37 + 11);
      ref_mem[i]  = 8'(i * 37 + 11);
    end

    vecs[0] = '{1'b1, 32'h04,       32'hA1B2C3D4, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h04,       32'h0,        1'b0, 32'hA1B2C3D4};
    vecs[2] = '{1'b0, 32'h06,       32'h0,        1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h1C,       32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h1C,       32'h0,        1'b0, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 32'h20,       32'h0,        1'b1, 32'h0};
    vecs[6] = '{1'b1, 32'h01,       32'h12345678, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};
    vecs[8] = '{1'b1, 32'h00,       32'h11223344, 1'b0, 32'h0};
    vecs[9] = '{1'b0, 32'h00,       32'h0,        1'b0, 32'h11223344};

    // Reset with a request pending: the handshake must be discarded.
    rst_i           = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = 32'h0;
    bus.req_wdata_i = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    bus.req_valid_i = 1'b0;
    rst_i           = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk1("post_reset_resp",  bus.resp_valid_o, 1'b0);
      chk1("post_reset_write", bus.memWrite_o,   1'b0);
      chk1("post_reset_ready", bus.req_ready_o,  1'b1);
    end

    // Directed vectors.
    for (int v = 0; v < 10; v++)
      do_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].err, vecs[v].rdata);

    // Back-to-back loads with req_valid_i held high.
    wait_ready(ok);
    w1 = ref_word(32'h04);
    w2 = ref_word(32'h1C);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 32'h04;
    @(negedge clk);
    bus.req_addr_i  = 32'h1C;
    for (int j = 1; j <= 14; j++) begin
      chk1("b2b_ready", bus.req_ready_o, (j == 7) || (j == 14));
      chk1("b2b_resp",  bus.resp_valid_o, (j == 6) || (j == 13));
      chk1("b2b_read",  bus.memRead_o, (j <= 4) || (j >= 8 && j <= 11));
      if (j <= 4)               chk("b2b_addr1", bus.memAddr_o, 32'h04 + 32'(j - 1));
      if (j >= 8 && j <= 11)    chk("b2b_addr2", bus.memAddr_o, 32'h1C + 32'(j - 8));
      if (j == 6)               chk("b2b_rdata1", bus.resp_rdata_o, w1);
      if (j == 13)              chk("b2b_rdata2", bus.resp_rdata_o, w2);
      if (j == 8)               bus.req_valid_i = 1'b0;
      if (j < 14) @(negedge clk);
    end

    // Reset during the third cycle of a store.
    wait_ready(ok);
    old10 = ref_mem[10];
    old11 = ref_mem[11];
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = 32'h08;
    bus.req_wdata_i = 32'h55667788;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk1("rst_mid_wr1", bus.memWrite_o, 1'b1);
    chk ("rst_mid_addr1", bus.memAddr_o, 32'h08);
    @(negedge clk);
    chk1("rst_mid_wr2", bus.memWrite_o, 1'b1);
    chk ("rst_mid_addr2", bus.memAddr_o, 32'h09);
    chk ("rst_mid_data2", bus.memWData_o, 32'h77);
    rst_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst_i = 1'b1;
    for (int j = 4; j <= 9; j++) begin
      @(negedge clk);
      chk1("rst_mid_no_resp",  bus.resp_valid_o, 1'b0);
      chk1("rst_mid_no_write", bus.memWrite_o,   1'b0);
    end
    chk("rst_mid_byte0", 32'(mem[8]),  32'h88);
    chk("rst_mid_byte1", 32'(mem[9]),  32'h77);
    chk("rst_mid_byte2", 32'(mem[10]), 32'(old10));
    chk("rst_mid_byte3", 32'(mem[11]), 32'(old11));
    ref_mem[8] = 8'h88;
    ref_mem[9] = 8'h77;

    // Random transactions against the reference memory.
    for (int n = 0; n < 60; n++) begin
      bit          wr;
      int unsigned sel;
      logic [31:0] addr, wdata;
      bit          e;
      wr    = 1'($urandom_range(0, 1));
      sel   = $urandom_range(0, 9);
      if (sel == 0)      addr = $urandom;
      else if (sel == 1) addr = 32'($urandom_range(0, DEPTH + 8));
      else               addr = 32'(4 * $urandom_range(0, DEPTH / 4 - 1));
      wdata = $urandom;
      e     = ref_err(addr);
      do_txn(wr, addr, wdata, e, (e || wr) ? 32'd0 : ref_word(addr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
